// File: rtl/ram_infr_pkg.sv
// ram_infr_pkg: shared constants for the dual-port inferred RAM.
//   DATA_W_DEF - default word width in bits
//   ADDR_W_DEF - default address width
//   DEPTH_DEF  - default number of words (2**ADDR_W_DEF)
//   depth()    - word count for a given address width
package ram_infr_pkg;

  localparam int unsigned DATA_W_DEF = 4;
  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned DEPTH_DEF  = 2 ** ADDR_W_DEF;

  function automatic int unsigned depth(input int unsigned aw);
    return 2 ** aw;
  endfunction

endpackage

// File: rtl/ram_infr_port.sv
// ram_infr_port: one access port of the dual-port RAM.
// Qualifies the write request and registers the read-first output.
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset (clears dout)
//   we     - write enable
//   addr   - word address
//   din    - write data
//   rdata  - current array contents at addr (driven by the parent)
//   wen    - write strobe to the shared array (suppressed during reset)
//   waddr  - write address to the shared array
//   wdata  - write data to the shared array
//   dout   - registered read data
module ram_infr_port
  import ram_infr_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] rdata,
  output logic              wen,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] dout
);

  always_comb begin
    wen   = we & rst_n;
    waddr = addr;
    wdata = din;
  end

  // rdata reflects the array before this edge's writes land (NBA ordering),
  // which gives read-first behaviour on both same-port and cross-port access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dout <= '0;
    else        dout <= rdata;
  end

endmodule

// File: rtl/ram_infr.sv
// ram_infr: true dual-port synchronous RAM, one clock, read-first ports.
//   clk1          - clock, rising edge
//   rst_n         - asynchronous active-low reset (clears doa, dob, coll)
//   wea/addra/dia - port A write enable, address, write data
//   doa           - port A registered read data
//   web/addrb/dib - port B write enable, address, write data
//   dob           - port B registered read data
//   coll          - both ports wrote the same address on the previous edge
// On a write-write collision port A's data is stored and port B's dropped.
module ram_infr
  import ram_infr_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dia,
  output logic [DATA_W-1:0] doa,
  input  logic              web,
  input  logic [ADDR_W-1:0] addrb,
  input  logic [DATA_W-1:0] dib,
  output logic [DATA_W-1:0] dob,
  output logic              coll
);

  localparam int unsigned DEPTH = depth(ADDR_W);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              wen_a, wen_b;
  logic [ADDR_W-1:0] waddr_a, waddr_b;
  logic [DATA_W-1:0] wdata_a, wdata_b;
  logic              hit;

  ram_infr_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_a (
    .clk   (clk1),
    .rst_n (rst_n),
    .we    (wea),
    .addr  (addra),
    .din   (dia),
    .rdata (mem[addra]),
    .wen   (wen_a),
    .waddr (waddr_a),
    .wdata (wdata_a),
    .dout  (doa)
  );

  ram_infr_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_b (
    .clk   (clk1),
    .rst_n (rst_n),
    .we    (web),
    .addr  (addrb),
    .din   (dib),
    .rdata (mem[addrb]),
    .wen   (wen_b),
    .waddr (waddr_b),
    .wdata (wdata_b),
    .dout  (dob)
  );

  always_comb hit = wen_a & wen_b & (waddr_a == waddr_b);

  // Both ports write from one block so the array has a single driver;
  // port B yields to port A on a same-address write.
  always_ff @(posedge clk1) begin
    if (wen_a)         mem[waddr_a] <= wdata_a;
    if (wen_b && !hit) mem[waddr_b] <= wdata_b;
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) coll <= 1'b0;
    else        coll <= hit;
  end

endmodule

// File: tb/tb_ram_infr.sv
module tb_ram_infr;

  logic       clk1 = 1'b0;
  logic       rst_n;
  logic       wea, web;
  logic [3:0] addra, addrb, dia, dib;
  logic [3:0] doa, dob;
  logic       coll;

  int tests = 0;
  int fails = 0;

  ram_infr #(.DATA_W(4), .ADDR_W(4)) dut (
    .clk1  (clk1),
    .rst_n (rst_n),
    .wea   (wea),
    .addra (addra),
    .dia   (dia),
    .doa   (doa),
    .web   (web),
    .addrb (addrb),
    .dib   (dib),
    .dob   (dob),
    .coll  (coll)
  );

  always #5 clk1 = ~clk1;

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wea = 0; web = 0; addra = 0; addrb = 0; dia = 0; dib = 0;
    #3;
    tests++; if (doa !== 4'h0) begin fails++; $display("FAIL reset_doa got %h want 0", doa); end
    tests++; if (dob !== 4'h0) begin fails++; $display("FAIL reset_dob got %h want 0", dob); end
    tests++; if (coll !== 1'b0) begin fails++; $display("FAIL reset_coll got %b want 0", coll); end
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_parallel();
    wea = 1; addra = 4'd6; dia = 4'hA;
    web = 1; addrb = 4'd7; dib = 4'hB;
    tick();
    tests++; if (coll !== 1'b0) begin fails++; $display("FAIL par_coll1 got %b want 0", coll); end
    wea = 0; web = 0;
    tick();
    tests++; if (doa !== 4'hA) begin fails++; $display("FAIL par_doa got %h want a", doa); end
    tests++; if (dob !== 4'hB) begin fails++; $display("FAIL par_dob got %h want b", dob); end
    tests++; if (coll !== 1'b0) begin fails++; $display("FAIL par_coll2 got %b want 0", coll); end
  endtask

  task automatic test_read_first();
    wea = 1; addra = 4'd6; dia = 4'hC;
    tick();
    tests++; if (doa !== 4'hA) begin fails++; $display("FAIL rf_old got %h want a", doa); end
    wea = 0;
    tick();
    tests++; if (doa !== 4'hC) begin fails++; $display("FAIL rf_new got %h want c", doa); end
  endtask

  task automatic test_cross();
    wea = 1; addra = 4'd2; dia = 4'h5; web = 0;
    tick();
    wea = 1; addra = 4'd2; dia = 4'h0; addrb = 4'd2;
    tick();
    tests++; if (dob !== 4'h5) begin fails++; $display("FAIL cross_old got %h want 5", dob); end
    wea = 0;
    tick();
    tests++; if (dob !== 4'h0) begin fails++; $display("FAIL cross_new got %h want 0", dob); end
  endtask

  task automatic test_collision();
    wea = 1; web = 1; addra = 4'd9; addrb = 4'd9; dia = 4'h3; dib = 4'h4;
    tick();
    tests++; if (coll !== 1'b1) begin fails++; $display("FAIL coll_set got %b want 1", coll); end
    wea = 0; web = 0;
    tick();
    tests++; if (coll !== 1'b0) begin fails++; $display("FAIL coll_clr got %b want 0", coll); end
    tests++; if (doa !== 4'h3) begin fails++; $display("FAIL coll_doa got %h want 3", doa); end
    tests++; if (dob !== 4'h3) begin fails++; $display("FAIL coll_dob got %h want 3", dob); end
    // back-to-back collisions hold the flag
    wea = 1; web = 1; addra = 4'd1; addrb = 4'd1; dia = 4'h7; dib = 4'h8;
    tick();
    tests++; if (coll !== 1'b1) begin fails++; $display("FAIL b2b_1 got %b want 1", coll); end
    addra = 4'd4; addrb = 4'd4;
    tick();
    tests++; if (coll !== 1'b1) begin fails++; $display("FAIL b2b_2 got %b want 1", coll); end
    // both write, different addresses: no collision, both stored
    addra = 4'd10; addrb = 4'd11; dia = 4'hD; dib = 4'hE;
    tick();
    tests++; if (coll !== 1'b0) begin fails++; $display("FAIL nocoll got %b want 0", coll); end
    wea = 0; web = 0; addra = 4'd4; addrb = 4'd11;
    tick();
    tests++; if (doa !== 4'h7) begin fails++; $display("FAIL b2b_doa got %h want 7", doa); end
    tests++; if (dob !== 4'hE) begin fails++; $display("FAIL diff_dob got %h want e", dob); end
  endtask

  task automatic test_sweep();
    logic [3:0] k4;
    web = 0;
    for (int k = 0; k < 16; k++) begin
      k4 = 4'(k);
      wea = 1; addra = k4; dia = k4;
      tick();
    end
    wea = 0;
    for (int k = 0; k < 17; k++) begin
      k4 = 4'(k % 16);
      addrb = k4;
      tick();
      tests++;
      if (dob !== k4) begin fails++; $display("FAIL sweep[%0d] got %h want %h", k, dob, k4); end
    end
  endtask

  task automatic test_reset_mid();
    wea = 0; web = 0; addra = 4'd6; addrb = 4'd6;
    tick();
    tests++; if (doa !== 4'h6) begin fails++; $display("FAIL pre_rst_doa got %h want 6", doa); end
    tests++; if (dob !== 4'h6) begin fails++; $display("FAIL pre_rst_dob got %h want 6", dob); end
    // set up a collision so coll would be 1 if not for reset
    wea = 1; web = 1; addra = 4'd3; addrb = 4'd3; dia = 4'h1; dib = 4'h2;
    tick();
    tests++; if (coll !== 1'b1) begin fails++; $display("FAIL pre_rst_coll got %b want 1", coll); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (doa !== 4'h0) begin fails++; $display("FAIL mid_rst_doa got %h want 0", doa); end
    tests++; if (dob !== 4'h0) begin fails++; $display("FAIL mid_rst_dob got %h want 0", dob); end
    tests++; if (coll !== 1'b0) begin fails++; $display("FAIL mid_rst_coll got %b want 0", coll); end
    web = 0; addra = 4'd6; dia = 4'hF;
    tick(); tick();
    tests++; if (doa !== 4'h0) begin fails++; $display("FAIL hold_rst_doa got %h want 0", doa); end
    tests++; if (coll !== 1'b0) begin fails++; $display("FAIL hold_rst_coll got %b want 0", coll); end
    wea = 0;
    rst_n = 1'b1;
    tick();
    tests++; if (doa !== 4'h6) begin fails++; $display("FAIL rst_nowrite got %h want 6", doa); end
  endtask

  initial begin
    test_reset();
    test_parallel();
    test_read_first();
    test_cross();
    test_collision();
    test_sweep();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
